line_sensor_decoder: RTL and testbench
======================================

Name: line_sensor_decoder

Overview:
- Front end that produces the `node_detected` level and the signed steering `error` consumed by the node-counting logic and the motor controller.
- Takes three 12-bit line-sensor ADC samples (left, centre, right) per conversion and classifies each sensor as dark or white against a threshold.
- Debounces the all-dark pattern into a clean node level plus a one-cycle pulse.
- Computes a saturated signed line-position error.

Parameters:
- THRESHOLD, 12'd1500, ADC value at or above which a sensor reads dark (line).
- NODE_CONFIRM, 4, consecutive valid all-dark samples required to assert node_detected (1..15).
- CLEAR_CONFIRM, 6, consecutive valid not-all-dark samples required to deassert node_detected (1..15).
- ERR_SHIFT, 4, arithmetic right shift applied to (right - left) before saturation.
- LOST_ERR, 8'sd100, error magnitude driven when no sensor is dark.

Ports:
- clk_50  in  1  50 MHz system clock.
- reset_n  in  1  synchronous active-low reset.
- sample_valid  in  1  one-cycle strobe; the three ADC inputs are valid this cycle.
- left_adc  in  12  left sensor sample, unsigned.
- center_adc  in  12  centre sensor sample, unsigned.
- right_adc  in  12  right sensor sample, unsigned.
- node_detected  out  1  debounced node level.
- node_pulse  out  1  one-cycle pulse on the rising edge of node_detected.
- error  out  8 signed  line-position error; positive means the line is to the right.
- line_lost  out  1  high while the latest sample has no dark sensor.
- out_valid  out  1  one-cycle strobe; error and line_lost were updated this cycle.

Behaviour:
- Reset: reset_n low at a clk_50 edge clears all outputs to 0, both debounce counters to 0, the pipeline valids to 0 and last_dir to 0. The FSM goes to OFF_NODE. All registers use reset_n; no asynchronous reset anywhere.
- Stage 1 (edge with sample_valid=1):
  - Capture the three samples and v1 <= 1.
  - Samples presented while sample_valid=0 are ignored.
- Stage 2 (edge with v1=1):
  - Compute dark[2:0] = {left>=THRESHOLD, center>=THRESHOLD, right>=THRESHOLD}.
  - Compute diff = right - left as 13-bit signed, then diff >>> ERR_SHIFT.
  - v2 <= 1.
- Stage 3 (edge with v2=1):
  - If any dark bit is set: error <= diff saturated to [-127, +127], line_lost <= 0, last_dir <= sign of diff (0 counts as positive).
  - If dark == 000: line_lost <= 1 and error <= +LOST_ERR or -LOST_ERR per last_dir; this holds the last turn direction.
  - out_valid <= 1 for exactly one cycle.
- Latency: sample_valid at edge N produces out_valid and updated error at edge N+2. Back-to-back sample_valid is accepted every cycle, throughput 1.
- Debounce FSM, evaluated at stage 3 only (v2=1); the all-dark condition is dark == 111:
  - OFF_NODE + all-dark: on_cnt++. When on_cnt reaches NODE_CONFIRM, go to ON_NODE, node_detected <= 1, node_pulse <= 1, on_cnt <= 0.
  - OFF_NODE + not all-dark: on_cnt <= 0.
  - ON_NODE + not all-dark: off_cnt++. When off_cnt reaches CLEAR_CONFIRM, go to OFF_NODE, node_detected <= 0, off_cnt <= 0.
  - ON_NODE + all-dark: off_cnt <= 0.
- node_pulse is high for exactly one clock per node and is 0 in all other cycles.
- Counters are 4 bits wide and saturate; they cannot wrap because the thresholds are at most 15.
- Exact boundaries:
  - ADC == THRESHOLD counts as dark.
  - A diff of exactly -128 after the shift saturates to -127.
  - diff is computed before the shift, so 12-bit extremes cannot overflow.
- Reset mid-pipeline discards in-flight samples; no out_valid follows the reset.
- sample_valid arriving together with reset_n=0 is dropped.

Decomposition:
- Shared package sm_line_pkg:
  - ADC_W=12 and ERR_W=8.
  - The state encoding OFF_NODE=1'b0 / ON_NODE=1'b1.
  - A saturate-to-signed-8 function, also used by the motor PID.
- One sub-module: node_debounce. It contains the FSM and the two counters, with inputs valid and all_dark, and outputs node_detected and node_pulse.
- The top level holds the pipeline and the error arithmetic.

Test Plan:
- Reset released with no samples -> every output stays 0 indefinitely; node_pulse never fires.
- Samples L=200, C=3000, R=200 -> error=0, line_lost=0, out_valid exactly 2 cycles after each sample_valid.
- L=0, C=0, R=4095 (ERR_SHIFT=4) -> diff>>>4=255, error=+127. Then L=4095, R=0 -> error=-127.
- 3 samples all 3000, then 1 white, then 4 samples all 3000 -> node_detected rises only after the 4th consecutive dark sample; node_pulse is 1 cycle high, once.
- In ON_NODE: 5 white samples, 1 dark, then 6 white -> node_detected falls only on the 6th consecutive white sample.
- Last error positive, then all sensors 100 -> line_lost=1, error=+100. Assert reset_n=0 one cycle after a sample_valid -> no out_valid follows and all outputs read 0.

Source files
------------

// File: rtl/line_sensor_decoder_pkg.sv
// Shared types and helpers for the line-sensor front end and the motor PID.
package sm_line_pkg;

  localparam int unsigned ADC_W = 12;
  localparam int unsigned ERR_W = 8;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    OFF_NODE = 1'b0,
    ON_NODE  = 1'b1
  } node_state_e;

  // Clamp a signed 16-bit value into the symmetric range [-127, +127].
  function automatic logic signed [ERR_W-1:0] sat_s8(input logic signed [15:0] x);
    logic signed [ERR_W-1:0] r;
    if (x > 16'sd127) begin
      r = 8'sd127;
    end else if (x < -16'sd127) begin
      r = -8'sd127;
    end else begin
      r = x[ERR_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/line_sensor_decoder_if.sv
// Sample input strobe/data and decoded result bundle for line_sensor_decoder.
interface line_sensor_decoder_if;
  import sm_line_pkg::*;

  logic                    sample_valid;
  logic [ADC_W-1:0]        left_adc;
  logic [ADC_W-1:0]        center_adc;
  logic [ADC_W-1:0]        right_adc;
  logic                    node_detected;
  logic                    node_pulse;
  logic signed [ERR_W-1:0] error;
  logic                    line_lost;
  logic                    out_valid;

  // Sample producer side.
  modport master (
    output sample_valid, left_adc, center_adc, right_adc,
    input  node_detected, node_pulse, error, line_lost, out_valid
  );

  // Decoder side.
  modport slave (
    input  sample_valid, left_adc, center_adc, right_adc,
    output node_detected, node_pulse, error, line_lost, out_valid
  );

endinterface

// File: rtl/line_sensor_decoder_node_debounce.sv
// Debounces the all-dark sensor pattern into a node level and a one-cycle pulse.
module node_debounce
  import sm_line_pkg::*;
#(
  parameter int unsigned NODE_CONFIRM  = 4,
  parameter int unsigned CLEAR_CONFIRM = 6
) (
  input  logic clk_50,
  input  logic reset_n,
  input  logic valid,
  input  logic all_dark,
  output logic node_detected,
  output logic node_pulse
);

  localparam logic [CNT_W-1:0] ON_TGT  = CNT_W'(NODE_CONFIRM);
  localparam logic [CNT_W-1:0] OFF_TGT = CNT_W'(CLEAR_CONFIRM);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  node_state_e      state_q, state_d;
  logic [CNT_W-1:0] on_cnt_q, on_cnt_d;
  logic [CNT_W-1:0] off_cnt_q, off_cnt_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] on_inc, off_inc;

  // Saturating increments so the counters can never wrap.
  always_comb begin
    on_inc  = (on_cnt_q == '1)  ? on_cnt_q  : on_cnt_q + CNT_ONE;
    off_inc = (off_cnt_q == '1) ? off_cnt_q : off_cnt_q + CNT_ONE;
  end

  // Next-state and counter logic; only advances on a valid classified sample.
  always_comb begin
    state_d   = state_q;
    on_cnt_d  = on_cnt_q;
    off_cnt_d = off_cnt_q;
    pulse_d   = 1'b0;
    if (valid) begin
      case (state_q)
        OFF_NODE: begin
          if (all_dark) begin
            if (on_inc == ON_TGT) begin
              state_d  = ON_NODE;
              on_cnt_d = '0;
              pulse_d  = 1'b1;
            end else begin
              on_cnt_d = on_inc;
            end
          end else begin
            on_cnt_d = '0;
          end
        end
        ON_NODE: begin
          if (!all_dark) begin
            if (off_inc == OFF_TGT) begin
              state_d   = OFF_NODE;
              off_cnt_d = '0;
            end else begin
              off_cnt_d = off_inc;
            end
          end else begin
            off_cnt_d = '0;
          end
        end
        default: state_d = OFF_NODE;
      endcase
    end
  end

  // State, counters and pulse registers.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_q   <= OFF_NODE;
      on_cnt_q  <= '0;
      off_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      on_cnt_q  <= on_cnt_d;
      off_cnt_q <= off_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign node_detected = (state_q == ON_NODE);
  assign node_pulse    = pulse_q;

endmodule

// File: rtl/line_sensor_decoder.sv
// Three-stage line-sensor pipeline: capture, classify/difference, saturate/debounce.
module line_sensor_decoder
  import sm_line_pkg::*;
#(
  parameter logic [ADC_W-1:0]        THRESHOLD     = 12'd1500,
  parameter int unsigned             NODE_CONFIRM  = 4,
  parameter int unsigned             CLEAR_CONFIRM = 6,
  parameter int unsigned             ERR_SHIFT     = 4,
  parameter logic signed [ERR_W-1:0] LOST_ERR      = 8'sd100
) (
  input logic            clk_50,
  input logic            reset_n,
  line_sensor_decoder_if.slave sif
);

  // Stage 1: captured samples.
  logic [ADC_W-1:0] left_q, center_q, right_q;
  logic             v1_q;

  // Stage 2: classification and shifted difference.
  logic [2:0]             dark_d, dark_q;
  logic signed [ADC_W:0]  diff_full, diff_d, diff_q;
  logic                   v2_q;

  // Stage 3: results.
  logic signed [ERR_W-1:0] error_q, error_d;
  logic                    lost_q, lost_d;
  logic                    last_dir_q, last_dir_d;
  logic                    out_valid_q;

  logic all_dark;
  logic node_det, node_pls;

  // Stage 1: register the samples only when strobed.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      left_q   <= '0;
      center_q <= '0;
      right_q  <= '0;
      v1_q     <= 1'b0;
    end else begin
      v1_q <= sif.sample_valid;
      if (sif.sample_valid) begin
        left_q   <= sif.left_adc;
        center_q <= sif.center_adc;
        right_q  <= sif.right_adc;
      end
    end
  end

  // Stage 2 combinational: threshold compare and difference widened before the shift.
  always_comb begin
    dark_d    = {left_q >= THRESHOLD, center_q >= THRESHOLD, right_q >= THRESHOLD};
    diff_full = $signed({1'b0, right_q}) - $signed({1'b0, left_q});
    diff_d    = diff_full >>> ERR_SHIFT;
  end

  // Stage 2 registers.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      dark_q <= '0;
      diff_q <= '0;
      v2_q   <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        dark_q <= dark_d;
        diff_q <= diff_d;
      end
    end
  end

  // Stage 3 combinational: saturated error, or held turn direction when the line is lost.
  always_comb begin
    error_d    = error_q;
    lost_d     = lost_q;
    last_dir_d = last_dir_q;
    if (v2_q) begin
      if (|dark_q) begin
        error_d    = sat_s8({{(16 - ADC_W - 1){diff_q[ADC_W]}}, diff_q});
        lost_d     = 1'b0;
        last_dir_d = diff_q[ADC_W];
      end else begin
        lost_d  = 1'b1;
        error_d = last_dir_q ? -LOST_ERR : LOST_ERR;
      end
    end
  end

  // Stage 3 registers.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      error_q     <= '0;
      lost_q      <= 1'b0;
      last_dir_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      error_q     <= error_d;
      lost_q      <= lost_d;
      last_dir_q  <= last_dir_d;
      out_valid_q <= v2_q;
    end
  end

  assign all_dark = &dark_q;

  node_debounce #(
    .NODE_CONFIRM (NODE_CONFIRM),
    .CLEAR_CONFIRM(CLEAR_CONFIRM)
  ) u_debounce (
    .clk_50       (clk_50),
    .reset_n      (reset_n),
    .valid        (v2_q),
    .all_dark     (all_dark),
    .node_detected(node_det),
    .node_pulse   (node_pls)
  );

  assign sif.node_detected = node_det;
  assign sif.node_pulse    = node_pls;
  assign sif.error         = error_q;
  assign sif.line_lost     = lost_q;
  assign sif.out_valid     = out_valid_q;

endmodule

// File: tb/tb_line_sensor_decoder.sv
// Directed self-checking bench for line_sensor_decoder.
module tb_line_sensor_decoder;

  logic clk_50 = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   pulse_cnt = 0;
  int   ov_cnt = 0;

  line_sensor_decoder_if sif ();

  line_sensor_decoder #(
    .THRESHOLD    (12'd1500),
    .NODE_CONFIRM (4),
    .CLEAR_CONFIRM(6),
    .ERR_SHIFT    (4),
    .LOST_ERR     (8'sd100)
  ) dut (
    .clk_50 (clk_50),
    .reset_n(reset_n),
    .sif    (sif)
  );

  always #10 clk_50 = ~clk_50;

  always @(negedge clk_50) begin
    if (sif.node_pulse === 1'b1) pulse_cnt++;
    if (sif.out_valid === 1'b1) ov_cnt++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    sif.left_adc     = l;
    sif.center_adc   = c;
    sif.right_adc    = r;
    sif.sample_valid = 1'b1;
  endtask

  // Presents one sample and returns #1 after the edge where its result lands.
  task automatic run_sample(input logic [11:0] l, input logic [11:0] c, input logic [11:0] r);
    drive(l, c, r);
    @(posedge clk_50); #1;
    sif.sample_valid = 1'b0;
    @(posedge clk_50);
    @(posedge clk_50); #1;
  endtask

  task automatic test_reset();
    int ov0, p0;
    reset_n = 1'b0;
    sif.sample_valid = 1'b0;
    sif.left_adc = '0; sif.center_adc = '0; sif.right_adc = '0;
    repeat (3) @(posedge clk_50);
    #1 reset_n = 1'b1;
    ov0 = ov_cnt; p0 = pulse_cnt;
    repeat (20) @(posedge clk_50);
    #1;
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", sif.out_valid); end
    checks++; if (sif.error !== 8'sd0) begin errors++; $display("FAIL reset_error got=%0d exp=0", sif.error); end
    checks++; if (sif.line_lost !== 1'b0) begin errors++; $display("FAIL reset_line_lost got=%b exp=0", sif.line_lost); end
    checks++; if (sif.node_detected !== 1'b0) begin errors++; $display("FAIL reset_node_detected got=%b exp=0", sif.node_detected); end
    checks++; if (sif.node_pulse !== 1'b0) begin errors++; $display("FAIL reset_node_pulse got=%b exp=0", sif.node_pulse); end
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL reset_idle_out_valid count=%0d exp=0", ov_cnt - ov0); end
    checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL reset_idle_pulse count=%0d exp=0", pulse_cnt - p0); end
  endtask

  task automatic test_latency();
    drive(12'd200, 12'd3000, 12'd200);
    @(posedge clk_50); #1;
    sif.sample_valid = 1'b0;
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL lat_n1 out_valid got=%b exp=0", sif.out_valid); end
    @(posedge clk_50); #1;
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL lat_n2pre out_valid got=%b exp=0", sif.out_valid); end
    @(posedge clk_50); #1;
    checks++; if (sif.out_valid !== 1'b1) begin errors++; $display("FAIL lat_n2 out_valid got=%b exp=1", sif.out_valid); end
    checks++; if (sif.error !== 8'sd0) begin errors++; $display("FAIL lat_error got=%0d exp=0", sif.error); end
    checks++; if (sif.line_lost !== 1'b0) begin errors++; $display("FAIL lat_line_lost got=%b exp=0", sif.line_lost); end
    @(posedge clk_50); #1;
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL lat_one_cycle out_valid got=%b exp=0", sif.out_valid); end
  endtask

  task automatic test_back_to_back();
    drive(12'd0, 12'd3000, 12'd1600);
    @(posedge clk_50); #1;
    drive(12'd1600, 12'd3000, 12'd0);
    @(posedge clk_50); #1;
    drive(12'd217, 12'd3000, 12'd200);
    @(posedge clk_50); #1;
    sif.sample_valid = 1'b0;
    checks++; if (sif.out_valid !== 1'b1 || sif.error !== 8'sd100) begin errors++; $display("FAIL b2b_first ov=%b err=%0d exp ov=1 err=100", sif.out_valid, sif.error); end
    @(posedge clk_50); #1;
    checks++; if (sif.out_valid !== 1'b1 || sif.error !== -8'sd100) begin errors++; $display("FAIL b2b_second ov=%b err=%0d exp ov=1 err=-100", sif.out_valid, sif.error); end
    @(posedge clk_50); #1;
    checks++; if (sif.out_valid !== 1'b1 || sif.error !== -8'sd2) begin errors++; $display("FAIL b2b_third_negshift ov=%b err=%0d exp ov=1 err=-2", sif.out_valid, sif.error); end
    @(posedge clk_50); #1;
    checks++; if (sif.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end out_valid got=%b exp=0", sif.out_valid); end
  endtask

  task automatic test_saturation();
    run_sample(12'd0, 12'd0, 12'd4095);
    checks++; if (sif.error !== 8'sd127) begin errors++; $display("FAIL sat_pos got=%0d exp=127", sif.error); end
    checks++; if (sif.line_lost !== 1'b0) begin errors++; $display("FAIL sat_pos_lost got=%b exp=0", sif.line_lost); end
    run_sample(12'd4095, 12'd0, 12'd0);
    checks++; if (sif.error !== -8'sd127) begin errors++; $display("FAIL sat_neg got=%0d exp=-127", sif.error); end
    run_sample(12'd2048, 12'd0, 12'd0);
    checks++; if (sif.error !== -8'sd127) begin errors++; $display("FAIL sat_m128 got=%0d exp=-127", sif.error); end
    run_sample(12'd0, 12'd0, 12'd2032);
    checks++; if (sif.error !== 8'sd127) begin errors++; $display("FAIL exact_127 got=%0d exp=127", sif.error); end
    run_sample(12'd1500, 12'd0, 12'd1500);
    checks++; if (sif.line_lost !== 1'b0 || sif.error !== 8'sd0) begin errors++; $display("FAIL thresh_eq lost=%b err=%0d exp lost=0 err=0", sif.line_lost, sif.error); end
    run_sample(12'd1499, 12'd1499, 12'd1499);
    checks++; if (sif.line_lost !== 1'b1 || sif.error !== 8'sd100) begin errors++; $display("FAIL thresh_below lost=%b err=%0d exp lost=1 err=100", sif.line_lost, sif.error); end
  endtask

  task automatic test_node_assert();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 3; i++) run_sample(12'd3000, 12'd3000, 12'd3000);
    checks++; if (sif.node_detected !== 1'b0) begin errors++; $display("FAIL node_after3 got=%b exp=0", sif.node_detected); end
    run_sample(12'd100, 12'd3000, 12'd100);
    checks++; if (sif.node_detected !== 1'b0) begin errors++; $display("FAIL node_after_white got=%b exp=0", sif.node_detected); end
    for (int i = 0; i < 3; i++) run_sample(12'd3000, 12'd3000, 12'd3000);
    checks++; if (sif.node_detected !== 1'b0) begin errors++; $display("FAIL node_after3_again got=%b exp=0", sif.node_detected); end
    run_sample(12'd3000, 12'd3000, 12'd3000);
    checks++; if (sif.node_detected !== 1'b1) begin errors++; $display("FAIL node_after4 got=%b exp=1", sif.node_detected); end
    checks++; if (sif.node_pulse !== 1'b1) begin errors++; $display("FAIL node_pulse_high got=%b exp=1", sif.node_pulse); end
    @(posedge clk_50); #1;
    checks++; if (sif.node_pulse !== 1'b0) begin errors++; $display("FAIL node_pulse_width got=%b exp=0", sif.node_pulse); end
    repeat (4) @(posedge clk_50);
    #1;
    checks++; if (pulse_cnt - p0 !== 1) begin errors++; $display("FAIL node_pulse_count got=%0d exp=1", pulse_cnt - p0); end
  endtask

  task automatic test_node_clear();
    int p0;
    p0 = pulse_cnt;
    for (int i = 0; i < 5; i++) run_sample(12'd100, 12'd3000, 12'd100);
    checks++; if (sif.node_detected !== 1'b1) begin errors++; $display("FAIL clear_after5 got=%b exp=1", sif.node_detected); end
    run_sample(12'd3000, 12'd3000, 12'd3000);
    checks++; if (sif.node_detected !== 1'b1) begin errors++; $display("FAIL clear_after_dark got=%b exp=1", sif.node_detected); end
    for (int i = 0; i < 5; i++) run_sample(12'd100, 12'd3000, 12'd100);
    checks++; if (sif.node_detected !== 1'b1) begin errors++; $display("FAIL clear_after5_again got=%b exp=1", sif.node_detected); end
    run_sample(12'd100, 12'd3000, 12'd100);
    checks++; if (sif.node_detected !== 1'b0) begin errors++; $display("FAIL clear_after6 got=%b exp=0", sif.node_detected); end
    checks++; if (pulse_cnt - p0 !== 0) begin errors++; $display("FAIL clear_no_pulse count=%0d exp=0", pulse_cnt - p0); end
  endtask

  task automatic test_line_lost();
    run_sample(12'd0, 12'd3000, 12'd1600);
    checks++; if (sif.error !== 8'sd100 || sif.line_lost !== 1'b0) begin errors++; $display("FAIL lost_setup_pos err=%0d lost=%b exp err=100 lost=0", sif.error, sif.line_lost); end
    run_sample(12'd100, 12'd100, 12'd100);
    checks++; if (sif.error !== 8'sd100 || sif.line_lost !== 1'b1) begin errors++; $display("FAIL lost_pos err=%0d lost=%b exp err=100 lost=1", sif.error, sif.line_lost); end
    run_sample(12'd1600, 12'd3000, 12'd0);
    checks++; if (sif.error !== -8'sd100 || sif.line_lost !== 1'b0) begin errors++; $display("FAIL lost_setup_neg err=%0d lost=%b exp err=-100 lost=0", sif.error, sif.line_lost); end
    run_sample(12'd100, 12'd100, 12'd100);
    checks++; if (sif.error !== -8'sd100 || sif.line_lost !== 1'b1) begin errors++; $display("FAIL lost_neg err=%0d lost=%b exp err=-100 lost=1", sif.error, sif.line_lost); end
    run_sample(12'd0, 12'd0, 12'd0);
    checks++; if (sif.error !== -8'sd100 || sif.line_lost !== 1'b1) begin errors++; $display("FAIL lost_hold err=%0d lost=%b exp err=-100 lost=1", sif.error, sif.line_lost); end
  endtask

  task automatic test_reset_midflight();
    int ov0;
    for (int i = 0; i < 4; i++) run_sample(12'd3000, 12'd3000, 12'd3000);
    checks++; if (sif.node_detected !== 1'b1) begin errors++; $display("FAIL mid_setup_node got=%b exp=1", sif.node_detected); end
    drive(12'd0, 12'd3000, 12'd1600);
    @(posedge clk_50); #1;
    sif.sample_valid = 1'b0;
    reset_n = 1'b0;
    ov0 = ov_cnt;
    @(posedge clk_50); #1;
    reset_n = 1'b1;
    checks++; if (sif.error !== 8'sd0 || sif.line_lost !== 1'b0 || sif.node_detected !== 1'b0 || sif.node_pulse !== 1'b0)
      begin errors++; $display("FAIL mid_outputs err=%0d lost=%b node=%b pulse=%b exp all 0", sif.error, sif.line_lost, sif.node_detected, sif.node_pulse); end
    repeat (5) @(posedge clk_50);
    #1;
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL mid_no_out_valid count=%0d exp=0", ov_cnt - ov0); end
    checks++; if (sif.error !== 8'sd0) begin errors++; $display("FAIL mid_error_after got=%0d exp=0", sif.error); end
    // Strobe coincident with reset must be dropped.
    reset_n = 1'b0;
    drive(12'd0, 12'd3000, 12'd4095);
    @(posedge clk_50); #1;
    sif.sample_valid = 1'b0;
    reset_n = 1'b1;
    ov0 = ov_cnt;
    repeat (5) @(posedge clk_50);
    #1;
    checks++; if (ov_cnt - ov0 !== 0) begin errors++; $display("FAIL drop_in_reset out_valid count=%0d exp=0", ov_cnt - ov0); end
    checks++; if (sif.error !== 8'sd0) begin errors++; $display("FAIL drop_in_reset error got=%0d exp=0", sif.error); end
  endtask

  initial begin
    sif.sample_valid = 1'b0;
    sif.left_adc     = '0;
    sif.center_adc   = '0;
    sif.right_adc    = '0;
    test_reset();
    test_latency();
    test_back_to_back();
    test_saturation();
    test_node_assert();
    test_node_clear();
    test_line_lost();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
